pipeline_elastic_buf: RTL and testbench

Parametrised elastic buffer for valid/ready streams: a DEPTH-entry register FIFO that replaces the single-stage pipeline register on paths needing more slack. It sustains one transfer per cycle, decouples timing by driving `in_ready` purely from internal state with no combinational path from `out_ready`, and reports occupancy, almost-full status and a synchronous flush. It sits between any two valid/ready stages in the datapath.

---
 rtl/pipeline_elastic_buf.sv | 88 ++++++++
 tb/tb_pipeline_elastic_buf.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_elastic_buf.sv
// Elastic buffer for valid/ready streams: a DEPTH-entry register FIFO.
// in_ready comes from registered occupancy only, so there is no path from out_ready.
module pipeline_elastic_buf #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           data_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           data_out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;

    assign in_ready    = (count_q != FULL_CNT);
    assign out_valid   = (count_q != '0);
    assign push        = in_valid && in_ready;
    assign pop         = out_valid && out_ready;
    assign data_out    = mem_q[rd_ptr_q];
    assign count       = count_q;
    assign almost_full = (count_q >= AF_CNT);

    // Explicit wrap at DEPTH-1 keeps non-power-of-2 depths correct.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // A flushed push must not land in storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !flush) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: tb/tb_pipeline_elastic_buf.sv
// Self-checking bench: DEPTH=4/WIDTH=32 and DEPTH=3/WIDTH=8 instances compared
// cycle by cycle against queue-based reference models.
module tb_pipeline_elastic_buf;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        fl4 = 1'b0, iv4 = 1'b0, ordy4 = 1'b0;
    logic [31:0] din4 = '0;
    logic        irdy4, ov4, af4;
    logic [31:0] dout4;
    logic [2:0]  cnt4;

    logic        fl3 = 1'b0, iv3 = 1'b0, ordy3 = 1'b0;
    logic [7:0]  din3 = '0;
    logic        irdy3, ov3, af3;
    logic [7:0]  dout3;
    logic [1:0]  cnt3;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] q4[$];
    logic [7:0]  q3[$];
    bit          lastRefused = 1'b0;

    always #5 clk = ~clk;

    pipeline_elastic_buf #(.WIDTH(32), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .flush(fl4), .in_valid(iv4), .in_ready(irdy4),
        .data_in(din4), .out_valid(ov4), .out_ready(ordy4), .data_out(dout4),
        .count(cnt4), .almost_full(af4)
    );

    pipeline_elastic_buf #(.WIDTH(8), .DEPTH(3), .AF_THRESH(2)) dut3 (
        .clk(clk), .rst(rst), .flush(fl3), .in_valid(iv3), .in_ready(irdy3),
        .data_in(din3), .out_valid(ov3), .out_ready(ordy3), .data_out(dout3),
        .count(cnt3), .almost_full(af3)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, observed, expected);
        end
    endtask

    // Called just after a falling edge: checks the current state against the
    // model, drives one cycle of inputs, then advances the model over the edge.
    task automatic applyStimulus(input bit sel, input bit iv, input logic [31:0] din,
                                 input bit ordy, input bit fl);
        int  sz;
        int  depth;
        int  afTh;
        bit  push;
        bit  pop;
        depth = sel ? 3 : 4;
        afTh  = sel ? 2 : 3;
        sz    = sel ? q3.size() : q4.size();
        if (sel) begin
            checkOutput("count3", 32'(cnt3), 32'(sz));
            checkOutput("out_valid3", 32'(ov3), 32'(sz != 0));
            checkOutput("in_ready3", 32'(irdy3), 32'(sz != depth));
            checkOutput("almost_full3", 32'(af3), 32'(sz >= afTh));
            if (sz > 0) checkOutput("data_out3", 32'(dout3), 32'(q3[0]));
            iv3 = iv; din3 = din[7:0]; ordy3 = ordy; fl3 = fl;
        end else begin
            checkOutput("count4", 32'(cnt4), 32'(sz));
            checkOutput("out_valid4", 32'(ov4), 32'(sz != 0));
            checkOutput("in_ready4", 32'(irdy4), 32'(sz != depth));
            checkOutput("almost_full4", 32'(af4), 32'(sz >= afTh));
            if (sz > 0) checkOutput("data_out4", dout4, q4[0]);
            iv4 = iv; din4 = din; ordy4 = ordy; fl4 = fl;
        end
        push = iv && (sz != depth);
        pop  = ordy && (sz != 0);
        lastRefused = iv && (sz == depth);
        @(posedge clk);
        if (fl) begin
            if (sel) q3.delete(); else q4.delete();
        end else begin
            if (pop)  begin if (sel) void'(q3.pop_front()); else void'(q4.pop_front()); end
            if (push) begin if (sel) q3.push_back(din[7:0]); else q4.push_back(din); end
        end
        @(negedge clk);
        iv4 = 1'b0; ordy4 = 1'b0; fl4 = 1'b0;
        iv3 = 1'b0; ordy3 = 1'b0; fl3 = 1'b0;
    endtask

    task automatic randomRun(input bit sel, input int cycles);
        logic [31:0] d;
        bit          iv;
        d = '0;
        lastRefused = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (!lastRefused) begin
                iv = ($urandom_range(0, 3) != 0);
                d  = $urandom;
            end else begin
                iv = 1'b1;
            end
            applyStimulus(sel, iv, d, $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
        end
    endtask

    initial begin
        #1;
        checkOutput("rst_count4", 32'(cnt4), 32'd0);
        checkOutput("rst_in_ready4", 32'(irdy4), 32'd1);
        checkOutput("rst_out_valid4", 32'(ov4), 32'd0);
        checkOutput("rst_data_out3", 32'(dout3), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Fill, then drain; full state also exercised with a refused push.
        for (int i = 0; i < 4; i++) applyStimulus(0, 1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 32'hDEAD, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b0);

        // Full with simultaneous pop: the push must be refused.
        for (int i = 0; i < 4; i++) applyStimulus(0, 1'b1, 32'hB0 + 32'(i), 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 32'hBAD0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b0);

        // Flush wins over a concurrent push and pop.
        applyStimulus(0, 1'b1, 32'hC0, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 32'hC1, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 32'hC2, 1'b1, 1'b1);
        applyStimulus(0, 1'b1, 32'h55, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Streaming at full rate.
        for (int i = 0; i < 100; i++) applyStimulus(0, 1'b1, 32'h1000 + 32'(i), 1'b1, 1'b0);
        applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset with three entries held.
        for (int i = 0; i < 3; i++) applyStimulus(0, 1'b1, 32'hE0 + 32'(i), 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        checkOutput("async_count", 32'(cnt4), 32'd0);
        checkOutput("async_out_valid", 32'(ov4), 32'd0);
        checkOutput("async_in_ready", 32'(irdy4), 32'd1);
        checkOutput("async_almost_full", 32'(af4), 32'd0);
        checkOutput("async_data_out", dout4, 32'd0);
        q4.delete();
        q3.delete();
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(0, 1'b1, 32'h77, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b0);

        randomRun(0, 300);
        randomRun(1, 300);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1'b0, 32'h0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
